deco_registro_seq: RTL and testbench
====================================

# deco_registro_seq

Parametrised register-load sequencer: it replaces an external 2-bit control counter feeding a fixed 3-output decoder with a self-contained counter-plus-decoder.

- On a start request it walks a one-hot load enable across `NUM_REG` destination registers, MSB first.
- Each enable is held for `HOLD_CYCLES` clocks.
- Completion is signalled with a one-cycle `done` pulse.
- It can optionally re-run continuously.
- It sits between the control FSM and the datapath register bank.

## Interface

Parameters:
- `NUM_REG`, default 3: number of destination registers and one-hot output width. Legal values are 2 or more.
- `HOLD_CYCLES`, default 1: clocks each enable stays asserted. Legal values are 1 or more.
- `IDX_W`, default `$clog2(NUM_REG)`: width of `indice`. Derived; do not override.

Ports:
- `clk`, input, 1 bit: single clock, rising edge.
- `reset`, input, 1 bit: asynchronous, active-low reset. Asserted (0) forces all state and outputs to reset values immediately.
- `start`, input, 1 bit: request a load sequence. Sampled only in IDLE.
- `abort`, input, 1 bit: synchronous cancel of any running sequence.
- `repetir`, input, 1 bit: auto-repeat mode. Sampled on the DONE cycle.
- `Salida_Reg`, output, `NUM_REG` bits: one-hot load enables, or all zero.
- `indice`, output, `IDX_W` bits: position of the active enable (bit number), 0 when no enable is active.
- `busy`, output, 1 bit: high in LOAD and DONE.
- `done`, output, 1 bit: one-cycle pulse at the end of a sequence.

## Operation

All outputs are registered. Reset values: `Salida_Reg`=0, `indice`=0, `busy`=0, `done`=0, state=IDLE, counters=0.

**States: IDLE, LOAD, DONE.**
- **IDLE:**
  - `start`=1 moves to LOAD.
  - Loads position `NUM_REG-1` and clears the hold counter.
- **LOAD:**
  - `Salida_Reg` has exactly one bit set, at the current position.
  - The hold counter counts 0..`HOLD_CYCLES-1`.
  - At terminal count with position>0: decrement position and clear the hold counter.
  - At terminal count with position=0: move to DONE.
- **DONE:**
  - `Salida_Reg`=0 and `done`=1 for exactly one cycle.
  - If `repetir`=1, go to LOAD with position `NUM_REG-1`.
  - Otherwise go to IDLE.

**Abort and start rules:**
- `abort`=1 in LOAD or DONE moves to IDLE next cycle with `Salida_Reg`=0 and `done`=0. No done pulse is produced.
- `abort` has priority over `start`, `repetir` and normal progression.
- `start` in LOAD or DONE is ignored. It is not queued.
- `start` and `abort` together in IDLE: stay in IDLE.

**Widths:**
- Position counter is `IDX_W` bits and never exceeds `NUM_REG-1`. It has no wrap-around; re-entry is by explicit reload.
- Hold counter is `$clog2(HOLD_CYCLES+1)` bits, minimum 1.
- `indice` equals the position counter in LOAD and 0 otherwise.
- For `NUM_REG`=3, `HOLD_CYCLES`=1 the enable sequence is 100, 010, 001, which matches the legacy decoder codes 01, 10, 11.

## Timing

**Single sequence** (start sampled high in IDLE at edge 0):
- Edge 1: `Salida_Reg`=bit `NUM_REG-1`, `busy`=1.
- Edge `1+k*HOLD_CYCLES`: enable moves to bit `NUM_REG-1-k`.
- Edge `NUM_REG*HOLD_CYCLES+1`: DONE, with `done`=1 and `Salida_Reg`=0.
- Next edge: IDLE (`busy`=0), or LOAD if `repetir`=1.

**Sequence length and throughput:**
- Sequence latency from start to done is `NUM_REG*HOLD_CYCLES+1` cycles.
- Repeat period is `NUM_REG*HOLD_CYCLES+1` cycles, with one all-zero gap cycle per pass.
- Back-to-back manual starts: `start` held high continuously gives a period of `NUM_REG*HOLD_CYCLES+2`.

**Reset and abort:**
- Reset asserted mid-sequence clears outputs asynchronously, without waiting for a clock edge.
- After reset deassertion, the first `start` behaves as from power-up.
- Abort latency is one edge. The enable active on the abort cycle still completes that cycle.

## Test plan

- **Reset:** pulse `reset` low mid-LOAD (`NUM_REG`=3) -> `Salida_Reg`=000, `busy`=0 before the next clock edge; then start -> 100 after one edge.
- **Defaults:** `NUM_REG`=3, `HOLD_CYCLES`=1, single start pulse -> `Salida_Reg` 100, 010, 001 on edges 1-3; `indice` 2, 1, 0; `done`=1 on edge 4 only; IDLE on edge 5.
- **Wide and held:** `NUM_REG`=8, `HOLD_CYCLES`=3 -> each bit 7..0 high for exactly 3 cycles; `done` at edge 25; never more than one bit set.
- **Repeat:** `repetir`=1 for two passes, `NUM_REG`=4, `HOLD_CYCLES`=1 -> 1000, 0100, 0010, 0001, 0000 with `done`=1, then 1000; drop `repetir` before the second DONE -> IDLE after it.
- **Abort:** `abort` at the second enable cycle (010) -> next cycle `Salida_Reg`=000, `done` never pulses; `start`+`abort` together in IDLE -> stays IDLE.
- **Ignored start:** `start` pulses during LOAD -> sequence unchanged, exactly one `done` per accepted start.

Source files
------------

// File: rtl/deco_registro_seq.sv
// Register-load sequencer: walks a one-hot load enable across NUM_REG registers,
// MSB first, holding each enable for HOLD_CYCLES clocks, then pulses done.
module deco_registro_seq #(
    parameter int NUM_REG     = 3,
    parameter int HOLD_CYCLES = 1,
    parameter int IDX_W       = $clog2(NUM_REG)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               repetir,
    output logic [NUM_REG-1:0] Salida_Reg,
    output logic [IDX_W-1:0]   indice,
    output logic               busy,
    output logic               done
);

    localparam int HOLD_W = ($clog2(HOLD_CYCLES + 1) > 1) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0]  LAST_POS  = IDX_W'(NUM_REG - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic [IDX_W-1:0]    pos_r;
    logic [IDX_W-1:0]    pos_s;
    logic [HOLD_W-1:0]   hold_r;
    logic [HOLD_W-1:0]   hold_s;

    logic [NUM_REG-1:0]  sal_s;
    logic [IDX_W-1:0]    idx_s;
    logic                busy_s;
    logic                done_s;

    function automatic logic [NUM_REG-1:0] one_hot(input logic [IDX_W-1:0] pos);
        logic [NUM_REG-1:0] v;
        v      = {NUM_REG{1'b0}};
        v[pos] = 1'b1;
        return v;
    endfunction

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            pos_r   <= {IDX_W{1'b0}};
            hold_r  <= {HOLD_W{1'b0}};
        end else begin
            state_r <= state_s;
            pos_r   <= pos_s;
            hold_r  <= hold_s;
        end
    end

    // Next-state logic; abort wins over start, repetir and normal progression.
    always_comb begin
        state_s = state_r;
        pos_s   = pos_r;
        hold_s  = hold_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_s = ST_LOAD;
                    pos_s   = LAST_POS;
                    hold_s  = {HOLD_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    state_s = ST_IDLE;
                    pos_s   = {IDX_W{1'b0}};
                    hold_s  = {HOLD_W{1'b0}};
                end else if (hold_r == HOLD_LAST) begin
                    hold_s = {HOLD_W{1'b0}};
                    if (pos_r != {IDX_W{1'b0}}) begin
                        pos_s = pos_r - IDX_W'(1);
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    hold_s = hold_r + HOLD_W'(1);
                end
            end
            ST_DONE: begin
                hold_s = {HOLD_W{1'b0}};
                if (abort) begin
                    state_s = ST_IDLE;
                    pos_s   = {IDX_W{1'b0}};
                end else if (repetir) begin
                    state_s = ST_LOAD;
                    pos_s   = LAST_POS;
                end else begin
                    state_s = ST_IDLE;
                    pos_s   = {IDX_W{1'b0}};
                end
            end
            default: begin
                state_s = ST_IDLE;
                pos_s   = {IDX_W{1'b0}};
                hold_s  = {HOLD_W{1'b0}};
            end
        endcase
    end

    // Output decode from the next state so registered outputs track the state without lag.
    always_comb begin
        sal_s  = {NUM_REG{1'b0}};
        idx_s  = {IDX_W{1'b0}};
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_s)
            ST_LOAD: begin
                sal_s  = one_hot(pos_s);
                idx_s  = pos_s;
                busy_s = 1'b1;
            end
            ST_DONE: begin
                busy_s = 1'b1;
                done_s = 1'b1;
            end
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Salida_Reg <= {NUM_REG{1'b0}};
            indice     <= {IDX_W{1'b0}};
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            Salida_Reg <= sal_s;
            indice     <= idx_s;
            busy       <= busy_s;
            done       <= done_s;
        end
    end

endmodule

// File: tb/tb_deco_registro_seq.sv
// Directed bench for deco_registro_seq: three instances cover the default,
// wide/held and repeat configurations.
module tb_deco_registro_seq;

    logic clk;
    logic reset;

    logic       a_start, a_abort, a_rep;
    logic [2:0] a_sal;
    logic [1:0] a_idx;
    logic       a_busy, a_done;

    logic       b_start, b_abort, b_rep;
    logic [7:0] b_sal;
    logic [2:0] b_idx;
    logic       b_busy, b_done;

    logic       c_start, c_abort, c_rep;
    logic [3:0] c_sal;
    logic [1:0] c_idx;
    logic       c_busy, c_done;

    int compared;
    int mismatched;

    deco_registro_seq #(.NUM_REG(3), .HOLD_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .abort(a_abort), .repetir(a_rep),
        .Salida_Reg(a_sal), .indice(a_idx), .busy(a_busy), .done(a_done)
    );

    deco_registro_seq #(.NUM_REG(8), .HOLD_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .abort(b_abort), .repetir(b_rep),
        .Salida_Reg(b_sal), .indice(b_idx), .busy(b_busy), .done(b_done)
    );

    deco_registro_seq #(.NUM_REG(4), .HOLD_CYCLES(1)) dut_c (
        .clk(clk), .reset(reset), .start(c_start), .abort(c_abort), .repetir(c_rep),
        .Salida_Reg(c_sal), .indice(c_idx), .busy(c_busy), .done(c_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] c_exp_sal [11];
        logic       c_exp_done[11];
        logic       c_exp_busy[11];
        int         dones;
        int         pos;

        compared   = 0;
        mismatched = 0;
        reset   = 1'b0;
        a_start = 1'b0; a_abort = 1'b0; a_rep = 1'b0;
        b_start = 1'b0; b_abort = 1'b0; b_rep = 1'b0;
        c_start = 1'b0; c_abort = 1'b0; c_rep = 1'b0;

        // Reset values
        #3;
        chk("rst_sal", 32'(a_sal), 32'd0);
        chk("rst_idx", 32'(a_idx), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        #9 reset = 1'b1;
        step();

        // Defaults: 100, 010, 001, done, idle
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        chk("def_e1_sal", 32'(a_sal), 32'b100);
        chk("def_e1_idx", 32'(a_idx), 32'd2);
        chk("def_e1_busy", 32'(a_busy), 32'd1);
        chk("def_e1_done", 32'(a_done), 32'd0);
        step();
        chk("def_e2_sal", 32'(a_sal), 32'b010);
        chk("def_e2_idx", 32'(a_idx), 32'd1);
        step();
        chk("def_e3_sal", 32'(a_sal), 32'b001);
        chk("def_e3_idx", 32'(a_idx), 32'd0);
        chk("def_e3_done", 32'(a_done), 32'd0);
        step();
        chk("def_e4_sal", 32'(a_sal), 32'b000);
        chk("def_e4_done", 32'(a_done), 32'd1);
        chk("def_e4_busy", 32'(a_busy), 32'd1);
        step();
        chk("def_e5_done", 32'(a_done), 32'd0);
        chk("def_e5_busy", 32'(a_busy), 32'd0);
        chk("def_e5_sal", 32'(a_sal), 32'b000);

        // Asynchronous reset mid-LOAD
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        step();
        chk("rstm_pre_sal", 32'(a_sal), 32'b010);
        reset = 1'b0;
        #1;
        chk("rstm_sal", 32'(a_sal), 32'b000);
        chk("rstm_busy", 32'(a_busy), 32'd0);
        chk("rstm_idx", 32'(a_idx), 32'd0);
        #1 reset = 1'b1;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        chk("rstm_restart_sal", 32'(a_sal), 32'b100);
        step();
        step();
        step();
        chk("rstm_done", 32'(a_done), 32'd1);
        step();
        chk("rstm_idle", 32'(a_busy), 32'd0);

        // Abort at the second enable
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        step();
        chk("abt_pre_sal", 32'(a_sal), 32'b010);
        a_abort = 1'b1;
        step();
        a_abort = 1'b0;
        chk("abt_sal", 32'(a_sal), 32'b000);
        chk("abt_busy", 32'(a_busy), 32'd0);
        chk("abt_done", 32'(a_done), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("abt_no_done", 32'(a_done), 32'd0);
            chk("abt_no_sal", 32'(a_sal), 32'b000);
        end

        // start and abort together in IDLE
        a_start = 1'b1;
        a_abort = 1'b1;
        step();
        a_start = 1'b0;
        a_abort = 1'b0;
        chk("sa_busy", 32'(a_busy), 32'd0);
        chk("sa_sal", 32'(a_sal), 32'b000);
        step();
        chk("sa_busy2", 32'(a_busy), 32'd0);

        // Starts during LOAD and DONE are ignored
        dones = 0;
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        chk("ign_e1_sal", 32'(a_sal), 32'b100);
        a_start = 1'b1;
        step();
        chk("ign_e2_sal", 32'(a_sal), 32'b010);
        step();
        a_start = 1'b0;
        chk("ign_e3_sal", 32'(a_sal), 32'b001);
        step();
        if (a_done === 1'b1) dones++;
        chk("ign_e4_sal", 32'(a_sal), 32'b000);
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        chk("ign_e5_busy", 32'(a_busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            if (a_done === 1'b1) dones++;
        end
        chk("ign_idle_busy", 32'(a_busy), 32'd0);
        chk("ign_done_count", 32'(dones), 32'd1);

        // Wide and held: NUM_REG=8, HOLD_CYCLES=3
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            if (cyc <= 24) begin
                pos = 7 - (cyc - 1) / 3;
                chk("wide_sal", 32'(b_sal), 32'd1 << pos);
                chk("wide_idx", 32'(b_idx), 32'(pos));
                chk("wide_onehot", 32'($onehot(b_sal)), 32'd1);
                chk("wide_done", 32'(b_done), 32'd0);
                step();
            end else begin
                chk("wide_e25_done", 32'(b_done), 32'd1);
                chk("wide_e25_sal", 32'(b_sal), 32'd0);
            end
        end
        step();
        chk("wide_idle_busy", 32'(b_busy), 32'd0);
        chk("wide_idle_done", 32'(b_done), 32'd0);

        // Repeat: NUM_REG=4, two passes, repetir dropped before second DONE
        c_exp_sal  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000,
                       4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b0000};
        c_exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        c_exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        c_rep   = 1'b1;
        c_start = 1'b1;
        step();
        c_start = 1'b0;
        for (int i = 0; i < 11; i++) begin
            chk("rep_sal", 32'(c_sal), 32'(c_exp_sal[i]));
            chk("rep_done", 32'(c_done), 32'(c_exp_done[i]));
            chk("rep_busy", 32'(c_busy), 32'(c_exp_busy[i]));
            if (i == 6) c_rep = 1'b0;
            if (i < 10) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
